// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

    localparam int unsigned REGARB_ADDR_W = 5;
    localparam int unsigned REGARB_DATA_W = 32;
    localparam int unsigned END_REG       = 26;
    localparam int unsigned RESULT_REG    = 20;

    typedef struct packed {
        logic [REGARB_ADDR_W-1:0] addr;
        logic [REGARB_DATA_W-1:0] data;
    } wb_req_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    logic [IDX_W-1:0] idx_c;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx_c     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx_c = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!gnt_valid && req[idx_c]) begin
                gnt[idx_c] = 1'b1;
                gnt_idx    = idx_c;
                gnt_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ one-entry writeback buffers.
// Optional REGARB_ZERO_GUARD_EN: grants to address 0 consume the slot but never assert wr_en.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = regfile_pkg::REGARB_ADDR_W,
    parameter int unsigned DATA_W  = regfile_pkg::REGARB_DATA_W,
    parameter int unsigned END_REG = regfile_pkg::END_REG
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic                       wr_hold,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       prog_done,
    output logic [NUM_REQ-1:0]         pending
);

    import regfile_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] buf_full_q, buf_full_d;
    logic [ADDR_W-1:0]  buf_addr_q [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] arb_req, grant_now, accept;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid, grant_write, end_hit;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;

    // Hold masks the request vector so ready never sees a grant while frozen.
    assign arb_req = wr_hold ? '0 : buf_full_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .gnt       (grant_now),
        .gnt_idx   (grant_idx),
        .gnt_valid (grant_valid)
    );

    assign req_ready  = ~buf_full_q | grant_now;
    assign accept     = req_valid & req_ready;
    assign pending    = buf_full_q;
    assign grant_addr = buf_addr_q[grant_idx];
    assign grant_data = buf_data_q[grant_idx];
    assign rr_ptr_d   = IDX_W'(wrap_inc(32'(grant_idx), NUM_REQ));
    assign end_hit    = grant_valid && (grant_addr == ADDR_W'(END_REG)) && grant_data[0];

`ifdef REGARB_ZERO_GUARD_EN
    assign grant_write = grant_valid && (grant_addr != '0);
`else
    assign grant_write = grant_valid;
`endif

    // Clear on grant first, then set on accept, so a same-cycle reload stays full.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_full_d = buf_full_d & ~grant_now;
        buf_full_d = buf_full_d | accept;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                buf_addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
                buf_data_q[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_full_q <= '0;
            rr_ptr_q   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            grant_id   <= '0;
            prog_done  <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            wr_en      <= grant_write;
            if (grant_valid) begin
                wr_addr  <= grant_addr;
                wr_data  <= grant_data;
                grant_id <= grant_idx;
                rr_ptr_q <= rr_ptr_d;
            end
            if (end_hit) begin
                prog_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed steps plus random traffic vs a queue model.
module tb_regfile_write_arbiter;

    import regfile_pkg::*;

    localparam int N = 3;
    localparam int A = 5;
    localparam int D = 32;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*A-1:0]   req_addr = '0;
    logic [N*D-1:0]   req_data = '0;
    logic             wr_hold = 1'b0;
    logic             wr_en;
    logic [A-1:0]     wr_addr;
    logic [D-1:0]     wr_data;
    logic [1:0]       grant_id;
    logic             prog_done;
    logic [N-1:0]     pending;

    int n_vec = 0;
    int n_bad = 0;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (A),
        .DATA_W  (D),
        .END_REG (26)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_hold   (wr_hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .prog_done (prog_done),
        .pending   (pending)
    );

    always #5 clock = ~clock;

    // Register file as the downstream consumer sees it: sampled on negedge.
    logic [D-1:0] dut_regs [32] = '{default: '0};
    always @(negedge clock) if (wr_en) dut_regs[wr_addr] = wr_data;

    // Behavioural model: one slot per requester, a rotating priority start, and the register file.
    wb_req_t    m_buf [N];
    bit         m_full [N];
    int         m_ptr;
    logic       m_wr_en;
    logic [A-1:0] m_addr;
    logic [D-1:0] m_data;
    int         m_gid;
    logic       m_done;
    logic [D-1:0] m_regs [32] = '{default: '0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic h);
        if (h) return -1;
        for (int k = 0; k < N; k++) begin
            if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] full_vec();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_full[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_full[i] = 0;
        m_ptr = 0; m_wr_en = 0; m_addr = '0; m_data = '0; m_gid = 0; m_done = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".wr_en"}, 64'(wr_en), 64'(m_wr_en));
        check({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_addr));
        check({tag, ".wr_data"}, 64'(wr_data), 64'(m_data));
        check({tag, ".grant_id"}, 64'(grant_id), 64'(m_gid));
        check({tag, ".prog_done"}, 64'(prog_done), 64'(m_done));
        check({tag, ".pending"}, 64'(pending), 64'(full_vec()));
    endtask

    // One clock cycle: drive, check ready before the edge, advance model, check after the edge.
    task automatic step(input string tag, input logic [N-1:0] v, input logic [N*A-1:0] a,
                        input logic [N*D-1:0] d, input logic h);
        int g;
        logic [N-1:0] exp_ready;
        req_valid = v; req_addr = a; req_data = d; wr_hold = h;
        g = pick(h);
        for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i] || (g == i);
        #1;
        check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
        @(posedge clock);
        if (g >= 0) begin
            m_addr = m_buf[g].addr;
            m_data = m_buf[g].data;
            m_gid  = g;
            m_ptr  = (g + 1) % N;
            m_full[g] = 0;
`ifdef REGARB_ZERO_GUARD_EN
            m_wr_en = (m_addr != 0);
`else
            m_wr_en = 1'b1;
`endif
            if (m_addr == 26 && m_data[0]) m_done = 1'b1;
            if (m_wr_en) m_regs[m_addr] = m_data;
        end else begin
            m_wr_en = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && exp_ready[i]) begin
                m_full[i] = 1;
                m_buf[i].addr = a[i*A +: A];
                m_buf[i].data = d[i*D +: D];
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        check_outputs({tag, ".in_reset"});
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1 check({tag, ".ready_after"}, 64'(req_ready), 64'({N{1'b1}}));
    endtask

    initial begin
        logic [N-1:0]   rv;
        logic [N*A-1:0] ra;
        logic [N*D-1:0] rd;
        logic [A-1:0]   a1;
        model_reset();
        #7 reset_n = 1'b1;
        @(posedge clock);
        #1 check_outputs("reset");

        // Reset while buffer 1 is full and a write beat is on the port.
        step("rst_fill0", 3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'h1234}, 1'b0);
        step("rst_fill1", 3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h5678, 32'd0}, 1'b0);
        check("rst.wr_en_before", 64'(wr_en), 64'd1);
        do_reset("rst_mid");

        // Single request from requester 0.
        step("single_acc", 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0);
        step("single_wr", 3'b000, '0, '0, 1'b0);
        check("single.wr_en", 64'(wr_en), 64'd1);
        check("single.wr_data", 64'(wr_data), 64'hDEADBEEF);
        idle("single_idle", 1);
        check("single.reg5", 64'(dut_regs[5]), 64'hDEADBEEF);
        do_reset("rst2");

        // All requesters valid every cycle: grants rotate 0,1,2,...
        for (int c = 0; c < 9; c++) begin
            step("rr_all", 3'b111, {5'd3, 5'd2, 5'd1},
                 {32'(c + 300), 32'(c + 200), 32'(c + 100)}, 1'b0);
        end
        idle("rr_drain", 4);
        do_reset("rst3");

        // Same address from requesters 0 and 2: last granted wins.
        step("same_addr", 3'b101, {5'd20, 5'd0, 5'd20}, {32'h22, 32'd0, 32'h11}, 1'b0);
        idle("same_drain", 3);
        check("same.reg20", 64'(dut_regs[RESULT_REG]), 64'h22);

        // Freeze with buffers 0 and 1 full.
        step("hold_fill", 3'b011, {5'd0, 5'd11, 5'd10}, {32'd0, 32'hB1, 32'hA0}, 1'b1);
        for (int c = 0; c < 4; c++) step("hold", 3'b000, '0, '0, 1'b1);
        idle("hold_release", 3);

        // End flag behaviour and address 0 handling.
        step("end0", 3'b001, {5'd0, 5'd0, 5'd26}, {32'd0, 32'd0, 32'h0}, 1'b0);
        idle("end0_wr", 2);
        check("end0.prog_done", 64'(prog_done), 64'd0);
        step("end1", 3'b010, {5'd0, 5'd26, 5'd0}, {32'd0, 32'h1, 32'd0}, 1'b0);
        idle("end1_wr", 2);
        check("end1.prog_done", 64'(prog_done), 64'd1);
        step("zero", 3'b100, {5'd0, 5'd0, 5'd0}, {32'hBAD0, 32'd0, 32'd0}, 1'b0);
        idle("zero_wr", 2);
        check("end.sticky", 64'(prog_done), 64'd1);

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 4))
                    0: a1 = 5'd0;
                    1: a1 = 5'd5;
                    2: a1 = 5'd20;
                    3: a1 = 5'd26;
                    default: a1 = A'($urandom);
                endcase
                ra[i*A +: A] = a1;
                rd[i*D +: D] = $urandom;
            end
            step("rand", rv, ra, rd, ($urandom_range(0, 7) == 0));
        end
        idle("rand_drain", 4);

        for (int r = 0; r < 32; r++) check("regfile", 64'(dut_regs[r]), 64'(m_regs[r]));

        do_reset("rst_final");
        check("final.prog_done", 64'(prog_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (address / data / enable, sampled on negedge clock) among NUM_REQ writeback requesters (ALU, load unit, link/PC logic, ...).
- Each requester gets a one-entry holding buffer with valid/ready handshake.
- A round-robin arbiter drains the buffers into registered write-port outputs.
- Also raises a sticky program-end flag when the end-signal register is written.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- END_REG, 26, register index that carries the program-end signal

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester buffer can accept
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  flattened; requester i at [i*DATA_W +: DATA_W]
- wr_hold  in  1  controller freeze; no new grant while high
- wr_en  out  1  register-file write enable (regwrite)
- wr_addr  out  ADDR_W  register-file write address (writereg)
- wr_data  out  DATA_W  register-file write data (writedata)
- grant_id  out  $clog2(NUM_REQ)  requester index of current wr_en beat
- prog_done  out  1  sticky end-of-program flag
- pending  out  NUM_REQ  buffer-full flags, for stall logic

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-low (reset_n).
- Reset values (on reset_n low, any time, including mid-transfer):
  - all buffers empty
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0
  - prog_done=0, rr_ptr=0
  - req_ready follows as all-ones once reset_n is high
- Handshake:
  - req_ready[i] = ~buf_full[i] | grant_now[i]; combinational from registered state and wr_hold only, never from req_valid.
  - Transfer when req_valid[i] & req_ready[i] at posedge. Buffer i captures addr/data; buf_full[i] is set.
  - Simultaneous grant and new accept on the same requester: buffer is reloaded and stays full.
- Arbitration (combinational, each cycle):
  - If wr_hold=0 and any buf_full, grant the first full buffer at or after rr_ptr, searching upward with wrap at NUM_REQ-1 -> 0.
  - At posedge: granted buffer is cleared. wr_en<=1, wr_addr/wr_data<=buffer contents, grant_id<=index, rr_ptr<=index+1 (mod NUM_REQ).
  - No grant: wr_en<=0; wr_addr/wr_data hold their last value.
- Throughput and latency:
  - At most one write per cycle.
  - Latency from accept edge k to wr_en high: wr_en is high in the cycle after edge k+1, with no contention.
  - Outputs are stable from posedge, so the register file's negedge sample is safe.
- Ordering: writes to the same address from different requesters commit in grant order; the last granted wins. Per-requester order is preserved.
- wr_hold: blocks grants only. Empty buffers still accept, full buffers hold. wr_en drops to 0 at the next posedge.
- prog_done: set at the posedge that issues a grant with addr==END_REG and data[0]==1. Cleared only by reset_n.
- Starvation bound: a full buffer is granted within NUM_REQ cycles while wr_hold=0.

Optional Feature:
- Macro: REGARB_ZERO_GUARD_EN
- Defined:
  - A buffered write to address 0 is granted normally (it consumes the slot and advances rr_ptr), but wr_en stays 0 for that beat.
  - Register 0 is never written.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Shared package regfile_pkg:
  - ADDR_W/DATA_W defaults
  - END_REG=26 and RESULT_REG=20 constants
  - wb_req_t struct {addr, data}
- One sub-module: rr_arbiter (request vector + pointer -> one-hot grant and index). Reusable elsewhere.

Test Plan:
1. Reset mid-transfer: buffer 1 full, reset_n low -> immediately wr_en=0, pending=0, prog_done=0, req_ready all 1 after release.
2. Single request, requester 0 (addr 5, data 0xDEADBEEF) accepted at edge k:
   - wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=0 in the cycle after edge k+1
   - register file reads 0xDEADBEEF afterward
3. All 3 requesters valid every cycle for 9 cycles, rr_ptr=0 -> grant_id sequence 0,1,2,0,1,2,...; no requester waits more than 3 cycles.
4. Same address: requesters 0 and 2 both write addr 20 (0x11, 0x22) in the same cycle, rr_ptr=0 -> reg 20 ends at 0x22.
5. wr_hold=1 for 4 cycles with buffers 0,1 full -> wr_en=0 and req_ready[0,1]=0 throughout; grants resume the cycle after wr_hold falls.
6. End flag:
   - Write addr 26 data 0x0 -> prog_done=0.
   - Write addr 26 data 0x1 -> prog_done=1 after the grant edge; stays 1 across later writes.
   - With REGARB_ZERO_GUARD_EN, a write to addr 0 -> wr_en=0 that beat.
